simple_dual_rf_sched: RTL

//  Sequencer/arbiter in front of one simple_dual_rf data bank (1R port A, byte-write port B, shared en).

---
 rtl/simple_dual_rf_sched_pkg.sv | 15 +
 rtl/simple_dual_rf_sched_byte_merge.sv | 17 +
 rtl/simple_dual_rf_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/simple_dual_rf_sched_pkg.sv
// Shared types and helpers for the simple_dual_rf bank scheduler.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Offset-within-line width; lines are at least two words, so this is never zero.
    function automatic int calc_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/simple_dual_rf_sched_byte_merge.sv
// Column-wise merge: each column takes new_word where wen is set, else old_word.
module byte_merge #(
    parameter int NUM_COL   = 4,
    parameter int COL_WIDTH = 8
) (
    input  logic [NUM_COL*COL_WIDTH-1:0] old_word,
    input  logic [NUM_COL*COL_WIDTH-1:0] new_word,
    input  logic [NUM_COL-1:0]           wen,
    output logic [NUM_COL*COL_WIDTH-1:0] merged
);

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        assign merged[c*COL_WIDTH +: COL_WIDTH] = wen[c] ? new_word[c*COL_WIDTH +: COL_WIDTH]
                                                         : old_word[c*COL_WIDTH +: COL_WIDTH];
    end

endmodule

// File: rtl/simple_dual_rf_sched.sv
// Arbitrates the bank write port between line refills and single stores, and returns
// read data one cycle later with same-cycle write-collision bypass and hold-over.
module simple_dual_rf_sched
    import cache_pkg::*;
#(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LINE_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_valid,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic                          rd_rvalid,
    output logic [NUM_COL*COL_WIDTH-1:0]  rd_data,
    input  logic                          st_valid,
    output logic                          st_ready,
    input  logic [ADDR_WIDTH-1:0]         st_addr,
    input  logic [NUM_COL-1:0]            st_wen,
    input  logic [NUM_COL*COL_WIDTH-1:0]  st_data,
    input  logic                          rf_start,
    input  logic [ADDR_WIDTH-1:0]         rf_base,
    input  logic                          rf_valid,
    output logic                          rf_ready,
    input  logic [NUM_COL*COL_WIDTH-1:0]  rf_data,
    output logic                          rf_done,
    output logic                          ram_en,
    output logic [ADDR_WIDTH-1:0]         ram_addrA,
    input  logic [NUM_COL*COL_WIDTH-1:0]  ram_doutA,
    output logic [NUM_COL-1:0]            ram_wen,
    output logic [ADDR_WIDTH-1:0]         ram_addrB,
    output logic [NUM_COL*COL_WIDTH-1:0]  ram_dinB
);

    localparam int W     = NUM_COL * COL_WIDTH;
    localparam int OFF_W = calc_off_w(LINE_WORDS);

    sched_state_e          state_q, state_d;
    logic [OFF_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic                  rd_rvalid_q, rd_rvalid_d;
    logic [W-1:0]          hold_q, hold_d;
    logic [NUM_COL-1:0]    hit_wen_q, hit_wen_d;
    logic [W-1:0]          hit_din_q, hit_din_d;
    logic [W-1:0]          merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            line_base_q <= '0;
            rd_rvalid_q <= 1'b0;
            hold_q      <= '0;
            hit_wen_q   <= '0;
            hit_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            line_base_q <= line_base_d;
            rd_rvalid_q <= rd_rvalid_d;
            hold_q      <= hold_d;
            hit_wen_q   <= hit_wen_d;
            hit_din_q   <= hit_din_d;
        end
    end

    // Write-port mux: stores own the port in IDLE, refill beats in FILL.
    always_comb begin
        ram_wen   = '0;
        ram_addrB = st_addr;
        ram_dinB  = st_data;
        if (state_q == IDLE && st_valid) begin
            ram_wen = st_wen;
        end else if (state_q == FILL && rf_valid) begin
            ram_wen   = '1;
            ram_addrB = line_base_q | ADDR_WIDTH'(beat_cnt_q);
            ram_dinB  = rf_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        line_base_d = line_base_q;
        unique case (state_q)
            IDLE: if (rf_start) begin
                state_d     = FILL;
                beat_cnt_d  = '0;
                line_base_d = rf_base & ~ADDR_WIDTH'(LINE_WORDS - 1);
            end
            FILL: if (rf_valid) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (beat_cnt_q == OFF_W'(LINE_WORDS - 1))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The bank returns old data on a same-address collision, so remember what was written.
    always_comb begin
        hit_wen_d = '0;
        hit_din_d = ram_dinB;
        if (rd_valid && (|ram_wen) && rd_addr == ram_addrB)
            hit_wen_d = ram_wen;
    end

    byte_merge #(
        .NUM_COL  (NUM_COL),
        .COL_WIDTH(COL_WIDTH)
    ) u_bypass (
        .old_word(ram_doutA),
        .new_word(hit_din_q),
        .wen     (hit_wen_q),
        .merged  (merged)
    );

    // doutA is only meaningful in the rvalid cycle; afterwards the held copy is presented.
    always_comb begin
        rd_rvalid_d = rd_valid;
        rd_data     = rd_rvalid_q ? merged : hold_q;
        hold_d      = rd_data;
    end

    assign rd_rvalid = rd_rvalid_q;
    assign st_ready  = (state_q == IDLE);
    assign rf_ready  = (state_q == FILL);
    assign rf_done   = (state_q == DONE);
    assign ram_en    = rd_valid | (|ram_wen);
    assign ram_addrA = rd_addr;

endmodule
